// File: rtl/missile_object.sv
// Tank missile object: launch, flight, explosion and per-pixel drawing request.
module missile_object #(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned SCREEN_H       = 480,
    parameter int unsigned TANK_SIZE      = 32,
    parameter int unsigned MISSILE_SIZE   = 4,
    parameter int unsigned EXPLODE_SIZE   = 16,
    parameter int unsigned SPEED          = 4,
    parameter int unsigned EXPLODE_FRAMES = 8,
    parameter logic [7:0]  MISSILE_RGB    = 8'hFC,
    parameter logic [7:0]  EXPLODE_RGB    = 8'hE0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fire,
    input  logic [10:0] tankX,
    input  logic [10:0] tankY,
    input  logic [1:0]  tankDir,
    input  logic        collision,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        missileDrawingRequest,
    output logic [7:0]  missileRGB,
    output logic        missileActive
);

    localparam int unsigned POS_W = 12;
    // Wider compare width so tank offsets and edge sums never wrap.
    localparam int unsigned CMP_W = 14;
    localparam int unsigned CNT_W = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;

    localparam logic signed [CMP_W-1:0] C_OFF  = CMP_W'((TANK_SIZE - MISSILE_SIZE) / 2);
    localparam logic signed [CMP_W-1:0] E_OFF  = CMP_W'((EXPLODE_SIZE - MISSILE_SIZE) / 2);
    localparam logic signed [CMP_W-1:0] MS     = CMP_W'(MISSILE_SIZE);
    localparam logic signed [CMP_W-1:0] ES     = CMP_W'(EXPLODE_SIZE);
    localparam logic signed [CMP_W-1:0] TS     = CMP_W'(TANK_SIZE);
    localparam logic signed [CMP_W-1:0] SPD    = CMP_W'(SPEED);
    localparam logic signed [CMP_W-1:0] SW     = CMP_W'(SCREEN_W);
    localparam logic signed [CMP_W-1:0] SH     = CMP_W'(SCREEN_H);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(EXPLODE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLYING  = 2'd1,
        ST_EXPLODE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     fire_lat_q, fire_lat_d;
    logic                     coll_lat_q, coll_lat_d;
    logic signed [POS_W-1:0]  mx_q, mx_d;
    logic signed [POS_W-1:0]  my_q, my_d;
    logic [1:0]               dir_q, dir_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     req_q, req_d;
    logic [7:0]               rgb_q, rgb_d;
    logic                     active_q, active_d;

    logic signed [CMP_W-1:0]  mx_w, my_w;
    logic signed [CMP_W-1:0]  tx_w, ty_w;
    logic signed [CMP_W-1:0]  px_w, py_w;
    logic signed [CMP_W-1:0]  lx, ly;
    logic signed [CMP_W-1:0]  nx, ny;
    logic signed [CMP_W-1:0]  ex, ey;
    logic                     fly_hit, expl_hit;

    // Square fully on screen: 0 <= x, x+size <= width, same for y.
    function automatic logic in_bounds(input logic signed [CMP_W-1:0] x,
                                       input logic signed [CMP_W-1:0] y);
        in_bounds = !x[CMP_W-1] && ((x + MS) <= SW) &&
                    !y[CMP_W-1] && ((y + MS) <= SH);
    endfunction

    // Sign-extended operands and candidate positions for launch, flight and drawing.
    always_comb begin
        mx_w = CMP_W'(mx_q);
        my_w = CMP_W'(my_q);
        tx_w = CMP_W'(tankX);
        ty_w = CMP_W'(tankY);
        px_w = CMP_W'(pixelX);
        py_w = CMP_W'(pixelY);

        lx = tx_w + C_OFF;
        ly = ty_w + C_OFF;
        unique case (tankDir)
            2'd0:    ly = ty_w - MS;
            2'd1:    lx = tx_w + TS;
            2'd2:    ly = ty_w + TS;
            default: lx = tx_w - MS;
        endcase

        nx = mx_w;
        ny = my_w;
        unique case (dir_q)
            2'd0:    ny = my_w - SPD;
            2'd1:    nx = mx_w + SPD;
            2'd2:    ny = my_w + SPD;
            default: nx = mx_w - SPD;
        endcase

        ex = mx_w - E_OFF;
        ey = my_w - E_OFF;
        fly_hit  = (px_w >= mx_w) && (px_w < mx_w + MS) &&
                   (py_w >= my_w) && (py_w < my_w + MS);
        expl_hit = (px_w >= ex) && (px_w < ex + ES) &&
                   (py_w >= ey) && (py_w < ey + ES);
    end

    // Next-state, latches, motion and registered pixel outputs.
    always_comb begin
        state_d    = state_q;
        fire_lat_d = fire_lat_q;
        coll_lat_d = coll_lat_q;
        mx_d       = mx_q;
        my_d       = my_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        req_d      = 1'b0;
        rgb_d      = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                coll_lat_d = 1'b0;
                if (startOfFrame) begin
                    fire_lat_d = 1'b0;
                    if (fire_lat_q || fire) begin
                        dir_d = tankDir;
                        mx_d  = POS_W'(lx);
                        my_d  = POS_W'(ly);
                        if (in_bounds(lx, ly)) begin
                            state_d = ST_FLYING;
                        end
                    end
                end else begin
                    fire_lat_d = fire_lat_q || fire;
                end
            end
            ST_FLYING: begin
                fire_lat_d = 1'b0;
                if (fire_lat_q == 1'b0 && fly_hit) begin
                    req_d = 1'b1;
                    rgb_d = MISSILE_RGB;
                end
                if (startOfFrame) begin
                    coll_lat_d = 1'b0;
                    if (coll_lat_q || collision) begin
                        state_d = ST_EXPLODE;
                        cnt_d   = '0;
                    end else if (!in_bounds(nx, ny)) begin
                        state_d = ST_EXPLODE;
                        cnt_d   = '0;
                    end else begin
                        mx_d = POS_W'(nx);
                        my_d = POS_W'(ny);
                    end
                end else begin
                    coll_lat_d = coll_lat_q || collision;
                end
            end
            ST_EXPLODE: begin
                fire_lat_d = 1'b0;
                coll_lat_d = 1'b0;
                if (expl_hit) begin
                    req_d = 1'b1;
                    rgb_d = EXPLODE_RGB;
                end
                if (startOfFrame) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                fire_lat_d = 1'b0;
                coll_lat_d = 1'b0;
            end
        endcase

        active_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any flight without exploding.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            fire_lat_q <= 1'b0;
            coll_lat_q <= 1'b0;
            mx_q       <= '0;
            my_q       <= '0;
            dir_q      <= '0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            rgb_q      <= 8'h00;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fire_lat_q <= fire_lat_d;
            coll_lat_q <= coll_lat_d;
            mx_q       <= mx_d;
            my_q       <= my_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            rgb_q      <= rgb_d;
            active_q   <= active_d;
        end
    end

    assign missileDrawingRequest = req_q;
    assign missileRGB            = rgb_q;
    assign missileActive         = active_q;

endmodule

// File: tb/tb_missile_object.sv
// Randomized and directed bench for missile_object against a frame-level behavioural model.
module tb_missile_object;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        fire;
    logic [10:0] tankX;
    logic [10:0] tankY;
    logic [1:0]  tankDir;
    logic        collision;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        missileDrawingRequest;
    logic [7:0]  missileRGB;
    logic        missileActive;

    missile_object dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .fire                  (fire),
        .tankX                 (tankX),
        .tankY                 (tankY),
        .tankDir               (tankDir),
        .collision             (collision),
        .pixelX                (pixelX),
        .pixelY                (pixelY),
        .missileDrawingRequest (missileDrawingRequest),
        .missileRGB            (missileRGB),
        .missileActive         (missileActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Model: "flying"/"exploding" flags, integer position, frames of explosion remaining.
    bit m_flying, m_exploding, m_fire_pending, m_hit_pending;
    int m_x, m_y, m_dir, m_frames_left;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s got=%0h exp=%0h t=%0t", phase, tag, got, exp, $time);
        end
    endtask

    function automatic bit on_screen(input int x, input int y);
        return (x >= 0) && (x + 4 <= 640) && (y >= 0) && (y + 4 <= 480);
    endfunction

    function automatic bit in_square(input int px, input int py, input int x, input int y, input int sz);
        return (px >= x) && (px < x + sz) && (py >= y) && (py < y + sz);
    endfunction

    task automatic model_reset();
        m_flying = 0; m_exploding = 0; m_fire_pending = 0; m_hit_pending = 0;
        m_x = 0; m_y = 0; m_dir = 0; m_frames_left = 0;
    endtask

    // One clock of the model: returns the drawing expected after this edge, then advances.
    task automatic model_step(input bit sof, input bit f, input bit c, input int px, input int py,
                              output bit exp_req, output int exp_rgb);
        int lx, ly, nx, ny;
        exp_req = 0; exp_rgb = 0;
        if (m_flying && in_square(px, py, m_x, m_y, 4)) begin
            exp_req = 1; exp_rgb = 'hFC;
        end else if (m_exploding && in_square(px, py, m_x - 6, m_y - 6, 16)) begin
            exp_req = 1; exp_rgb = 'hE0;
        end

        if (m_flying) begin
            if (sof) begin
                nx = m_x + ((m_dir == 1) ? 4 : (m_dir == 3) ? -4 : 0);
                ny = m_y + ((m_dir == 2) ? 4 : (m_dir == 0) ? -4 : 0);
                if (m_hit_pending || c || !on_screen(nx, ny)) begin
                    m_flying = 0; m_exploding = 1; m_frames_left = 8;
                end else begin
                    m_x = nx; m_y = ny;
                end
                m_hit_pending = 0;
            end else if (c) begin
                m_hit_pending = 1;
            end
        end else if (m_exploding) begin
            if (sof) begin
                m_frames_left--;
                if (m_frames_left == 0) m_exploding = 0;
            end
        end else begin
            if (sof) begin
                if (m_fire_pending || f) begin
                    lx = int'(tankX) + 14; ly = int'(tankY) + 14;
                    case (int'(tankDir))
                        0: ly = int'(tankY) - 4;
                        1: lx = int'(tankX) + 32;
                        2: ly = int'(tankY) + 32;
                        default: lx = int'(tankX) - 4;
                    endcase
                    if (on_screen(lx, ly)) begin
                        m_flying = 1; m_x = lx; m_y = ly; m_dir = int'(tankDir);
                    end
                end
                m_fire_pending = 0;
            end else if (f) begin
                m_fire_pending = 1;
            end
        end
    endtask

    // Drive one clock of inputs, advance the model, and compare all outputs after the edge.
    task automatic tick(input bit s, input bit f, input bit c, input int px, input int py);
        bit exp_req;
        int exp_rgb;
        startOfFrame = s; fire = f; collision = c;
        pixelX = 11'(px); pixelY = 11'(py);
        model_step(s, f, c, px, py, exp_req, exp_rgb);
        @(posedge clk);
        #1;
        check_eq("req", 32'(missileDrawingRequest), 32'(exp_req));
        check_eq("rgb", 32'(missileRGB), 32'(exp_rgb));
        check_eq("active", 32'(missileActive), 32'(m_flying || m_exploding));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"}, 32'(missileDrawingRequest), 32'd0);
        check_eq({tag, "_rgb"}, 32'(missileRGB), 32'd0);
        check_eq({tag, "_active"}, 32'(missileActive), 32'd0);
    endtask

    task automatic run_explosion_out();
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, m_x, m_y);
            tick(1, 0, 0, m_x - 6, m_y - 6);
        end
        tick(0, 0, 0, m_x, m_y);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 0; fire = 0; collision = 0;
        tankX = '0; tankY = '0; tankDir = '0; pixelX = '0; pixelY = '0;
        model_reset();

        phase = "reset";
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        resetN = 1'b1;

        phase = "launch";
        tankX = 11'd100; tankY = 11'd200; tankDir = 2'd0;
        tick(0, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 114, 196);
        tick(0, 0, 0, 118, 196);
        tick(0, 0, 0, 117, 199);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 114, 192);
        tick(0, 0, 0, 114, 196);

        phase = "fire_filter";
        tankX = 11'd400;
        tick(0, 1, 0, 0, 0);
        tick(1, 1, 0, 114, 192);
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 114, 180);

        phase = "collision";
        tick(0, 0, 1, 114, 180);
        repeat (5) tick(0, 0, 0, 114, 180);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 108, 174);
        tick(0, 0, 0, 107, 174);
        tick(0, 0, 0, 123, 189);
        tick(0, 0, 0, 124, 189);
        tick(0, 0, 0, 114, 180);

        phase = "explode";
        run_explosion_out();

        phase = "early_fire";
        tankX = 11'd300; tankY = 11'd300; tankDir = 2'd2;
        tick(0, 1, 0, 0, 0);
        repeat (200) tick(0, 0, 0, 314, 332);
        tick(1, 0, 0, 314, 332);
        tick(0, 0, 0, 314, 332);
        tick(1, 0, 1, 314, 332);
        run_explosion_out();

        phase = "same_cycle";
        tankDir = 2'd3;
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 0, 296, 314);

        phase = "reset_flight";
        #2 resetN = 1'b0;
        #1 check_all_zero("async");
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        tick(1, 0, 0, 296, 314);
        tick(0, 0, 0, 290, 308);
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 0, 296, 314);
        tick(1, 0, 1, 0, 0);
        run_explosion_out();

        phase = "right_edge";
        tankX = 11'd600; tankY = 11'd100; tankDir = 2'd1;
        tick(0, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 632, 114);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 636, 114);
        tick(0, 0, 0, 635, 114);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 630, 108);
        tick(0, 0, 0, 639, 123);
        run_explosion_out();

        phase = "oob_launch";
        tankX = 11'd0; tankY = 11'd0; tankDir = 2'd0;
        tick(0, 1, 0, 0, 0);
        tick(1, 0, 0, 14, 0);
        tick(0, 0, 0, 14, 0);
        tankY = 11'd100;
        tick(1, 0, 0, 14, 96);
        tick(0, 0, 0, 14, 96);

        phase = "random";
        for (int i = 0; i < 5000; i++) begin
            int px, py;
            if ($urandom_range(3, 0) == 0) begin
                tankX   = 11'($urandom_range(700, 0));
                tankY   = 11'($urandom_range(520, 0));
                tankDir = 2'($urandom_range(3, 0));
            end
            if ($urandom_range(1, 0) == 1) begin
                px = m_x + int'($urandom_range(23, 0)) - 8;
                py = m_y + int'($urandom_range(23, 0)) - 8;
            end else begin
                px = int'($urandom_range(700, 0));
                py = int'($urandom_range(520, 0));
            end
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            tick(($urandom_range(9, 0) == 0), ($urandom_range(29, 0) == 0),
                 ($urandom_range(59, 0) == 0), px, py);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
